// File: rtl/branch_resolver.sv
// EX-stage branch resolution for the RV32I pipeline. It also holds the IF-stage
// BTB predictor with 2-bit counters and the branch/mispredict performance counters.
module branch_resolver #(
  parameter int DATA_WIDTH  = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] if_pc_i,
  output logic                  if_pred_taken_o,
  output logic [DATA_WIDTH-1:0] if_pred_target_o,
  input  logic                  ex_br_valid_i,
  input  logic                  ex_stall_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [DATA_WIDTH-1:0] ex_pc_i,
  input  logic [DATA_WIDTH-1:0] ex_target_i,
  input  logic                  ex_pred_taken_i,
  input  logic [DATA_WIDTH-1:0] ex_pred_target_i,
  output logic                  br_unsigned_o,
  input  logic                  br_less_i,
  input  logic                  br_equal_i,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  br_illegal_o,
  output logic [31:0]           br_count_o,
  output logic [31:0]           mispred_count_o
);

  localparam int IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;

  logic [BTB_ENTRIES-1:0] valid_reg;
  logic [1:0]             ctr_reg    [BTB_ENTRIES];
  logic [TAG_BITS-1:0]    tag_reg    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_reg [BTB_ENTRIES];
  logic [31:0]            br_count_reg;
  logic [31:0]            mispred_count_reg;

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic                if_hit;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic                taken;
  logic                legal;
  logic                resolve;
  logic                mispredict;
  logic [1:0]          ctr_next;

  // Prediction reads the table as it stood before this cycle's EX update.
  assign if_idx           = if_pc_i[IDX_BITS+1:2];
  assign if_tag           = if_pc_i[DATA_WIDTH-1:IDX_BITS+2];
  assign if_hit           = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign if_pred_taken_o  = if_hit & ctr_reg[if_idx][1];
  assign if_pred_target_o = if_pred_taken_o ? target_reg[if_idx] : if_pc_i + DATA_WIDTH'(4);

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (ex_funct3_i)
      3'b000:  taken = br_equal_i;
      3'b001:  taken = !br_equal_i;
      3'b100:  taken = br_less_i;
      3'b101:  taken = !br_less_i;
      3'b110:  taken = br_less_i;
      3'b111:  taken = !br_less_i;
      default: legal = 1'b0;
    endcase
  end

  assign br_unsigned_o = ex_funct3_i[1];
  assign br_illegal_o  = ex_br_valid_i & !ex_stall_i & !legal;
  assign resolve       = ex_br_valid_i & !ex_stall_i & legal;
  assign mispredict    = resolve & ((taken != ex_pred_taken_i) |
                                    (taken & ex_pred_taken_i & (ex_target_i != ex_pred_target_i)));
  assign redirect_o    = mispredict;
  assign redirect_pc_o = taken ? ex_target_i : ex_pc_i + DATA_WIDTH'(4);

  assign ex_idx = ex_pc_i[IDX_BITS+1:2];
  assign ex_tag = ex_pc_i[DATA_WIDTH-1:IDX_BITS+2];
  assign ex_hit = valid_reg[ex_idx] && (tag_reg[ex_idx] == ex_tag);

  // A miss that is taken allocates weakly-taken; a hit moves the counter by one, saturating.
  always_comb begin
    ctr_next = ctr_reg[ex_idx];
    if (!ex_hit) begin
      if (taken) ctr_next = 2'b10;
    end else if (taken) begin
      if (ctr_reg[ex_idx] != 2'b11) ctr_next = ctr_reg[ex_idx] + 2'b01;
    end else begin
      if (ctr_reg[ex_idx] != 2'b00) ctr_next = ctr_reg[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_reg[i] <= 2'b01;
    end else if (resolve) begin
      ctr_reg[ex_idx] <= ctr_next;
      if (taken) valid_reg[ex_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (resolve && taken) begin
      tag_reg[ex_idx]    <= ex_tag;
      target_reg[ex_idx] <= ex_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_count_reg      <= '0;
      mispred_count_reg <= '0;
    end else begin
      if (resolve && br_count_reg != 32'hFFFF_FFFF) br_count_reg <= br_count_reg + 32'd1;
      if (mispredict && mispred_count_reg != 32'hFFFF_FFFF)
        mispred_count_reg <= mispred_count_reg + 32'd1;
    end
  end

  assign br_count_o      = br_count_reg;
  assign mispred_count_o = mispred_count_reg;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: scoreboard of EX-stage expectations
// plus a behavioural BTB/counter model for predictions and perf counters.
module tb_branch_resolver;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] if_pc_i;
  logic        if_pred_taken_o;
  logic [31:0] if_pred_target_o;
  logic        ex_br_valid_i;
  logic        ex_stall_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        br_unsigned_o;
  logic        br_less_i;
  logic        br_equal_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        br_illegal_o;
  logic [31:0] br_count_o;
  logic [31:0] mispred_count_o;

  branch_resolver #(.DATA_WIDTH(32), .BTB_ENTRIES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_pc_i(if_pc_i), .if_pred_taken_o(if_pred_taken_o), .if_pred_target_o(if_pred_target_o),
    .ex_br_valid_i(ex_br_valid_i), .ex_stall_i(ex_stall_i), .ex_funct3_i(ex_funct3_i),
    .ex_pc_i(ex_pc_i), .ex_target_i(ex_target_i), .ex_pred_taken_i(ex_pred_taken_i),
    .ex_pred_target_i(ex_pred_target_i), .br_unsigned_o(br_unsigned_o),
    .br_less_i(br_less_i), .br_equal_i(br_equal_i), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .br_illegal_o(br_illegal_o),
    .br_count_o(br_count_o), .mispred_count_o(mispred_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        illegal;
    logic        uns;
  } exp_t;
  exp_t sb_q[$];

  // Reference BTB and counters
  logic        m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [1:0]  m_ctr [16];
  logic [31:0] m_br, m_mis;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0; m_ctr[i] = 2'b01; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_br = 0; m_mis = 0;
  endtask

  function automatic logic [32:0] model_pred(input logic [31:0] pc);
    logic [3:0] idx;
    logic       t;
    idx = pc[5:2];
    t = m_v[idx] && (m_tag[idx] == pc[31:6]) && m_ctr[idx][1];
    return {t, t ? m_tgt[idx] : pc + 32'd4};
  endfunction

  task automatic probe(input string name, input logic [31:0] pc);
    logic [32:0] p;
    @(negedge clk_i);
    if_pc_i = pc;
    p = model_pred(pc);
    #1;
    chk({name, ".pred_taken"}, {31'd0, if_pred_taken_o}, {31'd0, p[32]});
    chk({name, ".pred_target"}, if_pred_target_o, p[31:0]);
    $display("probe %s pc=%h taken=%0b target=%h", name, pc, if_pred_taken_o, if_pred_target_o);
  endtask

  task automatic branch(input string name, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptg,
                        input logic less, input logic eq, input logic stall);
    exp_t        e;
    logic        tk, legal, res, mis, hit;
    logic [3:0]  idx;
    logic [32:0] p;
    @(negedge clk_i);
    if_pc_i = pc; ex_br_valid_i = 1'b1; ex_stall_i = stall; ex_funct3_i = f3;
    ex_pc_i = pc; ex_target_i = tgt; ex_pred_taken_i = pt; ex_pred_target_i = ptg;
    br_less_i = less; br_equal_i = eq;
    case (f3)
      3'b000: tk = eq;
      3'b001: tk = !eq;
      3'b100, 3'b110: tk = less;
      3'b101, 3'b111: tk = !less;
      default: tk = 1'b0;
    endcase
    legal = !(f3 == 3'b010 || f3 == 3'b011);
    res = !stall && legal;
    mis = res && ((tk != pt) || (tk && pt && tgt != ptg));
    e.redirect = mis;
    e.rpc = tk ? tgt : pc + 32'd4;
    e.illegal = !stall && !legal;
    e.uns = f3[1];
    sb_q.push_back(e);
    p = model_pred(pc);
    #1;
    e = sb_q.pop_front();
    chk({name, ".redirect"}, {31'd0, redirect_o}, {31'd0, e.redirect});
    chk({name, ".redirect_pc"}, redirect_pc_o, e.rpc);
    chk({name, ".illegal"}, {31'd0, br_illegal_o}, {31'd0, e.illegal});
    chk({name, ".unsigned"}, {31'd0, br_unsigned_o}, {31'd0, e.uns});
    chk({name, ".pred_taken"}, {31'd0, if_pred_taken_o}, {31'd0, p[32]});
    $display("branch %s f3=%b pc=%h redirect=%0b rpc=%h stall=%0b", name, f3, pc,
             redirect_o, redirect_pc_o, stall);
    @(posedge clk_i);
    if (res) begin
      idx = pc[5:2];
      hit = m_v[idx] && (m_tag[idx] == pc[31:6]);
      if (hit) begin
        if (tk) begin
          if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'b01;
          m_tgt[idx] = tgt;
        end else if (m_ctr[idx] != 2'b00) m_ctr[idx] = m_ctr[idx] - 2'b01;
      end else if (tk) begin
        m_v[idx] = 1'b1; m_tag[idx] = pc[31:6]; m_tgt[idx] = tgt; m_ctr[idx] = 2'b10;
      end
      m_br = m_br + 1;
      if (mis) m_mis = m_mis + 1;
    end
    #1;
    chk({name, ".br_count"}, br_count_o, m_br);
    chk({name, ".mispred_count"}, mispred_count_o, m_mis);
    ex_br_valid_i = 1'b0; ex_stall_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; if_pc_i = 32'h100; ex_br_valid_i = 1'b0; ex_stall_i = 1'b0;
    ex_funct3_i = 3'b000; ex_pc_i = '0; ex_target_i = '0; ex_pred_taken_i = 1'b0;
    ex_pred_target_i = '0; br_less_i = 1'b0; br_equal_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    chk("reset.br_count", br_count_o, 32'd0);
    chk("reset.mispred_count", mispred_count_o, 32'd0);
    probe("reset", 32'h100);

    // Taken BEQ on an empty table allocates weakly-taken
    branch("beq_alloc", 3'b000, 32'h100, 32'h180, 1'b0, 32'h104, 1'b0, 1'b1, 1'b0);
    probe("after_alloc", 32'h100);
    chk("after_alloc.target_const", if_pred_target_o, 32'h180);

    // Counter 10 -> 01 -> 00
    branch("beq_nt1", 3'b000, 32'h100, 32'h180, 1'b1, 32'h180, 1'b0, 1'b0, 1'b0);
    branch("beq_nt2", 3'b000, 32'h100, 32'h180, 1'b0, 32'h104, 1'b0, 1'b0, 1'b0);
    probe("after_nt", 32'h100);

    // Correctly predicted unsigned and signed less-than
    branch("bltu", 3'b110, 32'h200, 32'h240, 1'b1, 32'h240, 1'b1, 1'b0, 1'b0);
    branch("blt", 3'b100, 32'h204, 32'h260, 1'b1, 32'h260, 1'b1, 1'b0, 1'b0);
    branch("bge_nt", 3'b101, 32'h208, 32'h280, 1'b0, 32'h20C, 1'b1, 1'b0, 1'b0);
    branch("bgeu_t", 3'b111, 32'h20C, 32'h2A0, 1'b0, 32'h210, 1'b0, 1'b0, 1'b0);

    // Illegal funct3 never redirects or counts
    branch("illegal010", 3'b010, 32'h220, 32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
    branch("illegal011", 3'b011, 32'h224, 32'h300, 1'b0, 32'h228, 1'b0, 1'b0, 1'b0);

    // Stalled mispredict resolves once, after the stall lifts
    for (int i = 0; i < 3; i++)
      branch("bne_stall", 3'b001, 32'h300, 32'h3C0, 1'b0, 32'h304, 1'b0, 1'b0, 1'b1);
    branch("bne_go", 3'b001, 32'h300, 32'h3C0, 1'b0, 32'h304, 1'b0, 1'b0, 1'b0);

    // Taken with a stale predicted target
    branch("tgt_mis", 3'b001, 32'h300, 32'h3E0, 1'b1, 32'h3C0, 1'b0, 1'b0, 1'b0);
    probe("tgt_update", 32'h300);

    // Aliasing on index 0
    branch("alias_a", 3'b000, 32'h400, 32'h480, 1'b0, 32'h404, 1'b0, 1'b1, 1'b0);
    probe("alias_a_hit", 32'h400);
    branch("alias_b", 3'b000, 32'h440, 32'h4C0, 1'b0, 32'h444, 1'b0, 1'b1, 1'b0);
    probe("alias_a_miss", 32'h400);
    probe("alias_b_hit", 32'h440);

    // PC+4 wraps to zero
    branch("wrap", 3'b001, 32'hFFFF_FFFC, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("wrap.rpc_const", redirect_pc_o, 32'h0);

    // Asynchronous reset mid-cycle clears table and counters immediately
    @(negedge clk_i);
    if_pc_i = 32'h440;
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("async_rst.br_count", br_count_o, 32'd0);
    chk("async_rst.mispred_count", mispred_count_o, 32'd0);
    chk("async_rst.pred_taken", {31'd0, if_pred_taken_o}, 32'd0);
    chk("async_rst.pred_target", if_pred_target_o, 32'h444);
    @(negedge clk_i);
    rst_ni = 1'b1;
    probe("post_rst", 32'h300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
